array_sort_check_datapath: RTL and testbench

- Datapath for the array sort checker; sits directly under the sort-check control FSM.
- Consumes the FSM's load_input, load_index and select_index; produces its inversion_found, end_of_array and zero_length_array status inputs.
- Owns the array storage: an internal register-file memory loaded through a write port by the upstream producer.
- Walks adjacent element pairs and reports the index of the first inversion found.

---
 rtl/array_sort_check_datapath_if.sv | 24 ++
 rtl/array_sort_check_datapath.sv | 55 +++++
 tb/tb_array_sort_check_datapath.sv | 138 +++++++++++++
 3 files changed

// File: rtl/array_sort_check_datapath_if.sv
// array_sort_check_datapath_if: control, write-port and status bundle between the sort-check FSM/producer and the datapath
interface array_sort_check_datapath_if #(parameter int WIDTH = 32, parameter int ADDR_W = 5);
  logic [ADDR_W-1:0] array_base;
  logic [ADDR_W:0]   length;
  logic              load_input;
  logic              load_index;
  logic              select_index;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              inversion_found;
  logic              end_of_array;
  logic              zero_length_array;
  logic              inversion_valid;
  logic [ADDR_W:0]   first_inversion;
  modport master (
    output array_base, length, load_input, load_index, select_index, wr_en, wr_addr, wr_data,
    input  inversion_found, end_of_array, zero_length_array, inversion_valid, first_inversion
  );
  modport slave (
    input  array_base, length, load_input, load_index, select_index, wr_en, wr_addr, wr_data,
    output inversion_found, end_of_array, zero_length_array, inversion_valid, first_inversion
  );
endinterface

// File: rtl/array_sort_check_datapath.sv
// array_sort_check_datapath: array storage plus adjacent-pair walker reporting the first out-of-order element
module array_sort_check_datapath #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5,
  parameter bit SIGNED = 1'b1
) (
  input logic clock,
  input logic reset,
  array_sort_check_datapath_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] baseR, addrA, addrB;
  logic [ADDR_W:0]   lenR, indexR, invIdxR;
  logic              invValidR, greater, found, clear;
  logic [WIDTH-1:0]  elemA, elemB;
  // Addresses wrap modulo DEPTH so an array may straddle the top of memory
  assign addrB   = baseR + indexR[ADDR_W-1:0];
  assign addrA   = addrB - 1'b1;
  assign elemA   = mem[addrA];
  assign elemB   = mem[addrB];
  assign greater = SIGNED ? ($signed(elemA) > $signed(elemB)) : (elemA > elemB);
  assign found   = (indexR != '0) & (indexR < lenR) & greater;
  assign clear   = bus.load_index & ~bus.select_index;
  assign bus.inversion_found   = found;
  assign bus.end_of_array      = ({1'b0, indexR} + 1'b1) >= {1'b0, lenR};
  assign bus.zero_length_array = (lenR == '0);
  assign bus.inversion_valid   = invValidR;
  assign bus.first_inversion   = invIdxR;
  always_ff @(posedge clock) begin
    if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      baseR     <= '0;
      lenR      <= '0;
      indexR    <= '0;
      invValidR <= 1'b0;
      invIdxR   <= '0;
    end else begin
      if (bus.load_input) begin
        baseR <= bus.array_base;
        lenR  <= bus.length;
      end
      if (bus.load_index) indexR <= !bus.select_index ? '0 : (&indexR) ? indexR : indexR + 1'b1;
      if (clear) begin
        invValidR <= 1'b0;
        invIdxR   <= '0;
      end else if (found && !invValidR) begin
        invValidR <= 1'b1;
        invIdxR   <= indexR;
      end
    end
  end
endmodule

// File: tb/tb_array_sort_check_datapath.sv
// tb_array_sort_check_datapath: directed table-driven check of the sort-check datapath, signed and unsigned builds
module tb_array_sort_check_datapath;
  logic        clock, reset;
  logic [4:0]  arrayBase, wrAddr;
  logic [5:0]  length;
  logic        loadInput, loadIndex, selectIndex, wrEn;
  logic [31:0] wrData;
  logic [9:0]  stS, stU;
  int total = 0, bad = 0;
  array_sort_check_datapath_if #(.WIDTH(32), .ADDR_W(5)) busS ();
  array_sort_check_datapath_if #(.WIDTH(32), .ADDR_W(5)) busU ();
  assign busS.array_base = arrayBase;   assign busU.array_base = arrayBase;
  assign busS.length = length;          assign busU.length = length;
  assign busS.load_input = loadInput;   assign busU.load_input = loadInput;
  assign busS.load_index = loadIndex;   assign busU.load_index = loadIndex;
  assign busS.select_index = selectIndex; assign busU.select_index = selectIndex;
  assign busS.wr_en = wrEn;             assign busU.wr_en = wrEn;
  assign busS.wr_addr = wrAddr;         assign busU.wr_addr = wrAddr;
  assign busS.wr_data = wrData;         assign busU.wr_data = wrData;
  assign stS = {busS.inversion_found, busS.end_of_array, busS.zero_length_array, busS.inversion_valid, busS.first_inversion};
  assign stU = {busU.inversion_found, busU.end_of_array, busU.zero_length_array, busU.inversion_valid, busU.first_inversion};
  array_sort_check_datapath #(.WIDTH(32), .ADDR_W(5), .SIGNED(1'b1)) dutS (.clock(clock), .reset(reset), .bus(busS));
  array_sort_check_datapath #(.WIDTH(32), .ADDR_W(5), .SIGNED(1'b0)) dutU (.clock(clock), .reset(reset), .bus(busU));
  initial clock = 1'b0;
  always #5 clock = ~clock;
  typedef struct {
    logic       li;
    logic [4:0] base;
    logic [5:0] len;
    logic       ldx, sel;
    logic [9:0] exp;
  } vec_t;
  vec_t vecs [14];
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string name, input logic [9:0] got, input logic [9:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got found/end/zero/valid/first=%b exp=%b", name, got, exp);
    end
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wrEn = 1'b1; wrAddr = a; wrData = d;
    tick();
    wrEn = 1'b0;
  endtask
  task automatic step(input logic ldx, input logic sel);
    loadIndex = ldx; selectIndex = sel;
    tick();
  endtask
  function automatic logic [9:0] st(input logic f, input logic e, input logic z, input logic v, input logic [5:0] fi);
    return {f, e, z, v, fi};
  endfunction
  initial begin
    vecs[0]  = '{1'b1, 5'd4, 6'd4, 1'b1, 1'b0, st(0, 0, 0, 0, 0)};
    vecs[1]  = '{1'b1, 5'd4, 6'd4, 1'b1, 1'b1, st(0, 0, 0, 0, 0)};
    vecs[2]  = '{1'b1, 5'd4, 6'd4, 1'b1, 1'b1, st(0, 0, 0, 0, 0)};
    vecs[3]  = '{1'b1, 5'd4, 6'd4, 1'b1, 1'b1, st(0, 1, 0, 0, 0)};
    vecs[4]  = '{1'b1, 5'd4, 6'd4, 1'b1, 1'b1, st(0, 1, 0, 0, 0)};
    vecs[5]  = '{1'b1, 5'd0, 6'd4, 1'b1, 1'b0, st(0, 0, 0, 0, 0)};
    vecs[6]  = '{1'b1, 5'd0, 6'd4, 1'b1, 1'b1, st(0, 0, 0, 0, 0)};
    vecs[7]  = '{1'b1, 5'd0, 6'd4, 1'b1, 1'b1, st(1, 0, 0, 0, 0)};
    vecs[8]  = '{1'b1, 5'd0, 6'd4, 1'b1, 1'b1, st(0, 1, 0, 1, 2)};
    vecs[9]  = '{1'b1, 5'd0, 6'd4, 1'b1, 1'b1, st(0, 1, 0, 1, 2)};
    vecs[10] = '{1'b1, 5'd0, 6'd4, 1'b0, 1'b1, st(0, 1, 0, 1, 2)};
    vecs[11] = '{1'b1, 5'd0, 6'd0, 1'b1, 1'b0, st(0, 1, 1, 0, 0)};
    vecs[12] = '{1'b1, 5'd4, 6'd1, 1'b1, 1'b0, st(0, 1, 0, 0, 0)};
    vecs[13] = '{1'b1, 5'd4, 6'd1, 1'b1, 1'b1, st(0, 1, 0, 0, 0)};
    reset = 1'b0; wrEn = 1'b0; wrAddr = '0; wrData = '0;
    arrayBase = '0; length = '0; loadInput = 1'b0; loadIndex = 1'b0; selectIndex = 1'b0;
    for (int i = 0; i < 4; i++) begin
      arrayBase = 5'($urandom); length = 6'($urandom); loadInput = 1'($urandom);
      loadIndex = 1'($urandom); selectIndex = 1'($urandom);
      tick();
      chk($sformatf("reset%0d", i), stS, st(0, 1, 1, 0, 0));
    end
    loadInput = 1'b0; loadIndex = 1'b0; selectIndex = 1'b0;
    reset = 1'b1;
    tick();
    wr(0, 1); wr(1, 7); wr(2, 2); wr(3, 8);
    wr(4, 3); wr(5, 5); wr(6, 5); wr(7, 9);
    for (int i = 0; i < 14; i++) begin
      loadInput = vecs[i].li; arrayBase = vecs[i].base; length = vecs[i].len;
      loadIndex = vecs[i].ldx; selectIndex = vecs[i].sel;
      tick();
      chk($sformatf("vec%0d", i), stS, vecs[i].exp);
    end
    loadIndex = 1'b0; loadInput = 1'b0;
    wr(31, 32'hFFFF_FFFC); wr(0, 0); wr(1, 3);
    loadInput = 1'b1; arrayBase = 5'd31; length = 6'd3;
    step(1, 0);
    chk("wrap_i0", stS, st(0, 0, 0, 0, 0));
    step(1, 1);
    chk("wrap_s_i1", stS, st(0, 0, 0, 0, 0));
    chk("wrap_u_i1", stU, st(1, 0, 0, 0, 0));
    step(1, 1);
    chk("wrap_s_i2", stS, st(0, 1, 0, 0, 0));
    chk("wrap_u_i2", stU, st(0, 1, 0, 1, 1));
    loadInput = 1'b0; loadIndex = 1'b0;
    for (int i = 0; i < 32; i++) wr(5'((7 + i) % 32), 32'(i));
    loadInput = 1'b1; arrayBase = 5'd7; length = 6'd32;
    step(1, 0);
    for (int k = 0; k < 32; k++) begin
      chk($sformatf("len32_i%0d", k), stS, st(0, k == 31, 0, 0, 0));
      step(1, 1);
    end
    step(1, 0); step(1, 1); step(1, 1);
    chk("rdw_before", stS, st(0, 0, 0, 0, 0));
    loadIndex = 1'b0;
    wrEn = 1'b1; wrAddr = 5'd9; wrData = 32'd0;
    #1;
    chk("rdw_write_cycle", stS, st(0, 0, 0, 0, 0));
    tick();
    wrEn = 1'b0;
    chk("rdw_after_edge", stS, st(1, 0, 0, 0, 0));
    tick();
    chk("rdw_capture", stS, st(1, 0, 0, 1, 2));
    #2;
    reset = 1'b0;
    #1;
    chk("mid_reset", stS, st(0, 1, 1, 0, 0));
    tick();
    reset = 1'b1;
    step(1, 0);
    chk("rerun_i0", stS, st(0, 0, 0, 0, 0));
    step(1, 1);
    chk("rerun_i1", stS, st(0, 0, 0, 0, 0));
    step(1, 1);
    chk("rerun_i2", stS, st(1, 0, 0, 0, 0));
    step(1, 1);
    chk("rerun_i3", stS, st(0, 0, 0, 1, 2));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
